// File: rtl/spad_mc_pkg.sv
// Shared scratchpad constants for gnpu tops instantiating several systolic arrays.
// Defaults for the multi-channel scratchpad geometry and address decoding.
package spad_mc_pkg;

  localparam int SPAD_ADDR_WIDTH = 32;
  localparam int SPAD_DATA_WIDTH = 256;
  localparam int SPAD_DEPTH      = 1024;
  localparam int SPAD_NUM_CH     = 2;
  localparam int SPAD_RQ_DEPTH   = 2;

  // Byte-offset bits dropped from an address to form a word index.
  function automatic int spad_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/spad_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after ptr, cyclically.
// The pointer moves to the slot after the winner; with no grant it holds.
module spad_rr_arb #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;
  int            sum;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, or a latch is inferred.
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = '0;
    sum   = 0;
    for (int i = 0; i < N; i++) begin
      // NOTE: blocking assignments here so later iterations see the updated found flag.
      sum = int'(ptr_q) + i;
      if (sum >= N) sum = sum - N;
      idx = PW'(sum);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = (idx == PW'(N - 1)) ? '0 : PW'(idx + 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/spad_mc.sv
// Multi-channel scratchpad: NUM_CH clients share one SRAM, one read and one write per cycle,
// round-robin arbitration, per-channel read response FIFOs with write-first bypass.
module spad_mc
  import spad_mc_pkg::*;
#(
  parameter int NUM_CH     = SPAD_NUM_CH,
  parameter int ADDR_WIDTH = SPAD_ADDR_WIDTH,
  parameter int DATA_WIDTH = SPAD_DATA_WIDTH,
  parameter int DEPTH      = SPAD_DEPTH,
  parameter int RQ_DEPTH   = SPAD_RQ_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            sarray_ar_valid_i,
  output logic [NUM_CH-1:0]            sarray_ar_ready_o,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] sarray_ar_addr_i,
  output logic [NUM_CH-1:0]            sarray_r_valid_o,
  input  logic [NUM_CH-1:0]            sarray_r_ready_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] sarray_r_data_o,
  input  logic [NUM_CH-1:0]            sarray_aw_valid_i,
  output logic [NUM_CH-1:0]            sarray_aw_ready_o,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] sarray_aw_addr_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] sarray_aw_data_i
);

  localparam int LSB = spad_lsb(DATA_WIDTH);
  localparam int IW  = $clog2(DEPTH);
  localparam int PW  = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int CW  = $clog2(RQ_DEPTH + 1);

  logic [NUM_CH-1:0]     rd_req;
  logic                  rd_any, wr_any;
  logic [IW-1:0]         rd_idx, wr_idx;
  logic [DATA_WIDTH-1:0] wr_data, rd_word;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  unused_addr;

  spad_rr_arb #(.N(NUM_CH)) u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (rd_req),
    .gnt_o (sarray_ar_ready_o)
  );

  spad_rr_arb #(.N(NUM_CH)) u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (sarray_aw_valid_i),
    .gnt_o (sarray_aw_ready_o)
  );

  // Upper address bits wrap modulo DEPTH; byte-offset bits are ignored.
  assign unused_addr = ^{sarray_ar_addr_i, sarray_aw_addr_i};

  always_comb begin
    rd_any  = 1'b0;
    wr_any  = 1'b0;
    rd_idx  = '0;
    wr_idx  = '0;
    wr_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sarray_ar_ready_o[c]) begin
        rd_any = 1'b1;
        rd_idx = sarray_ar_addr_i[c*ADDR_WIDTH+LSB +: IW];
      end
      if (sarray_aw_ready_o[c]) begin
        wr_any  = 1'b1;
        wr_idx  = sarray_aw_addr_i[c*ADDR_WIDTH+LSB +: IW];
        wr_data = sarray_aw_data_i[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Same-cycle read of the word being written sees the new data.
  assign rd_word = (rd_any && wr_any && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];

  // NOTE: storage arrays carry no reset; only control state does, so the RAM maps to SRAM.
  always_ff @(posedge clk) begin
    if (wr_any) mem[wr_idx] <= wr_data;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] fifo_q [RQ_DEPTH];
    logic [PW-1:0]         wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  push, pop;

    assign push      = sarray_ar_ready_o[c];
    assign pop       = sarray_r_valid_o[c] && sarray_r_ready_i[c];
    assign rd_req[c] = sarray_ar_valid_i[c] && (cnt_q < CW'(RQ_DEPTH));

    always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (push) wp_d = (wp_q == PW'(RQ_DEPTH - 1)) ? '0 : PW'(wp_q + 1'b1);
      if (pop)  rp_d = (rp_q == PW'(RQ_DEPTH - 1)) ? '0 : PW'(rp_q + 1'b1);
      if (push && !pop)      cnt_d = CW'(cnt_q + 1'b1);
      else if (pop && !push) cnt_d = CW'(cnt_q - 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        wp_q  <= wp_d;
        rp_q  <= rp_d;
        cnt_q <= cnt_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push) fifo_q[wp_q] <= rd_word;
    end

    assign sarray_r_valid_o[c]                          = (cnt_q != '0);
    assign sarray_r_data_o[c*DATA_WIDTH +: DATA_WIDTH] = fifo_q[rp_q];
  end

endmodule

// File: tb/tb_spad_mc.sv
// Scoreboard bench for spad_mc: a reference memory predicts read data at each AR handshake,
// the response monitor pops and compares; arbitration order is checked against fixed sequences.
module tb_spad_mc;

  localparam int NC    = 2;
  localparam int AW    = 32;
  localparam int DW    = 256;
  localparam int DEPTH = 1024;
  localparam int RQ    = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NC-1:0]  ar_valid, ar_ready, r_valid, r_ready, aw_valid, aw_ready;
  logic [NC*AW-1:0] ar_addr, aw_addr;
  logic [NC*DW-1:0] r_data, aw_data;

  always #5 clk = ~clk;

  spad_mc #(
    .NUM_CH(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RQ_DEPTH(RQ)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sarray_ar_valid_i (ar_valid),
    .sarray_ar_ready_o (ar_ready),
    .sarray_ar_addr_i  (ar_addr),
    .sarray_r_valid_o  (r_valid),
    .sarray_r_ready_i  (r_ready),
    .sarray_r_data_o   (r_data),
    .sarray_aw_valid_i (aw_valid),
    .sarray_aw_ready_o (aw_ready),
    .sarray_aw_addr_i  (aw_addr),
    .sarray_aw_data_i  (aw_data)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_mem [int];
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  logic [DW-1:0] mon_d, mon_exp;
  int            mon_i;

  localparam logic [DW-1:0] D1 = {8{32'hD1D1_0001}};
  localparam logic [DW-1:0] D2 = {8{32'hD2D2_0002}};
  localparam logic [DW-1:0] D3 = {8{32'hD3D3_0003}};
  localparam logic [DW-1:0] D4 = {8{32'hD4D4_0004}};
  localparam logic [DW-1:0] D5 = {8{32'hD5D5_0005}};

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [AW-1:0] a);
    return int'((a / 32) % DEPTH);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: writes apply before same-cycle reads (write-first), then responses are popped.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NC; c++)
        if (aw_valid[c] && aw_ready[c])
          model_mem[widx(aw_addr[c*AW +: AW])] = aw_data[c*DW +: DW];
      for (int c = 0; c < NC; c++)
        if (ar_valid[c] && ar_ready[c]) begin
          mon_i = widx(ar_addr[c*AW +: AW]);
          mon_d = model_mem.exists(mon_i) ? model_mem[mon_i] : 'x;
          if (c == 0) exp_q0.push_back(mon_d);
          else        exp_q1.push_back(mon_d);
        end
      for (int c = 0; c < NC; c++)
        if (r_valid[c] && r_ready[c]) begin
          if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
            check($sformatf("r_unexpected_ch%0d", c), 1, 0);
          end else begin
            mon_exp = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check($sformatf("rdata_ch%0d", c), r_data[c*DW +: DW], mon_exp);
          end
        end
    end
  end

  initial begin
    rst_n    = 1'b0;
    ar_valid = '0; r_ready = '0; aw_valid = '0;
    ar_addr  = '0; aw_addr = '0; aw_data = '0;
    #1;
    check("rst_rvalid", r_valid, 0);
    check("rst_arready", ar_ready, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single channel write then read, one-cycle read latency
    cyc();
    aw_valid = 2'b01; aw_addr[0 +: AW] = 32'h40; aw_data[0 +: DW] = D1;
    #1 check("t1_awready", aw_ready, 2'b01);
    cyc();
    aw_valid = '0; ar_valid = 2'b01; ar_addr[0 +: AW] = 32'h40; r_ready = 2'b11;
    #1 check("t1_arready", ar_ready, 2'b01);
    check("t1_rvalid_pre", r_valid, 0);
    cyc();
    ar_valid = '0;
    #1 check("t1_rvalid_post", r_valid, 2'b01);
    cyc();

    // Two writers contend; write pointer sits at ch1 after the first write
    aw_valid = 2'b11;
    aw_addr[0 +: AW] = 32'h100; aw_data[0 +: DW] = D3;
    aw_addr[AW +: AW] = 32'h120; aw_data[DW +: DW] = D4;
    #1 check("t2_aw_first", aw_ready, 2'b10);
    cyc();
    aw_valid = 2'b01;
    #1 check("t2_aw_second", aw_ready, 2'b01);
    cyc();
    aw_valid = '0;

    // Both readers every cycle: grants alternate starting at ch1
    ar_valid = 2'b11; ar_addr[0 +: AW] = 32'h100; ar_addr[AW +: AW] = 32'h120;
    for (int k = 0; k < 6; k++) begin
      #1 check($sformatf("t2_ar_rr%0d", k), ar_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
      cyc();
    end
    ar_valid = '0;
    cyc(); cyc();

    // ch1 stalls its responses: two grants, then ch0 takes every cycle
    r_ready = 2'b01; ar_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1 check($sformatf("t3_ar%0d", k), ar_ready,
               (k == 0 || k == 2) ? 2'b10 : 2'b01);
      cyc();
    end
    ar_valid = 2'b10;
    #1 check("t3_full_block", ar_ready, 2'b00);
    check("t3_rvalid1", r_valid[1], 1'b1);
    ar_valid = '0;

    // Reset with ch1 holding two buffered reads
    #1 rst_n = 1'b0;
    #1 check("rst_async_rvalid", r_valid, 0);
    exp_q0.delete();
    exp_q1.delete();
    cyc(); cyc();
    #2 rst_n = 1'b1;
    r_ready = 2'b11;
    cyc();
    #1 check("rst_no_stale_a", r_valid, 0);
    cyc();
    #1 check("rst_no_stale_b", r_valid, 0);
    cyc();

    // Same-cycle write on ch0 and read on ch1 of the same word
    aw_valid = 2'b01; aw_addr[0 +: AW] = 32'h80; aw_data[0 +: DW] = D2;
    ar_valid = 2'b10; ar_addr[AW +: AW] = 32'h80;
    #1 check("t4_awready", aw_ready, 2'b01);
    check("t4_arready", ar_ready, 2'b10);
    cyc();
    aw_valid = '0; ar_valid = '0;
    #1 check("t4_rvalid", r_valid, 2'b10);
    cyc();

    // Address aliasing modulo DEPTH words
    aw_valid = 2'b01; aw_addr[0 +: AW] = 32'h40 + DEPTH * 32; aw_data[0 +: DW] = D5;
    #1 check("t5_awready", aw_ready, 2'b01);
    cyc();
    aw_valid = '0;
    ar_valid = 2'b11; ar_addr[0 +: AW] = 32'h40; ar_addr[AW +: AW] = 32'h40 + DEPTH * 32;
    #1 check("t5_ar_first", ar_ready, 2'b01);
    cyc();
    ar_valid = 2'b10;
    #1 check("t5_ar_second", ar_ready, 2'b10);
    cyc();
    ar_valid = '0;
    repeat (3) cyc();

    check("drain_ch0", DW'(exp_q0.size()), 0);
    check("drain_ch1", DW'(exp_q1.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
